multi_ch_clk_gen: RTL and testbench

- Synthesizable N-channel programmable clock/PWM generator.
- Each channel produces a periodic waveform. Period, high time (duty) and start phase are all counted in cycles of the system clock.
- New settings are written through a valid/ready config port into per-channel shadow registers. They take effect only at a period boundary, so a running waveform is never corrupted mid-period.
- The block feeds clock-enable and strobe generation for downstream test and peripheral logic.

---
 rtl/multi_ch_clk_gen.sv | 162 ++++++++++++++++
 tb/tb_multi_ch_clk_gen.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ch_clk_gen.sv
// N-channel programmable clock/PWM generator with per-channel period, high time and start phase.
// Config writes land in shadow registers and are applied only at IDLE exit or at a period boundary.
module multi_ch_clk_gen #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_ton,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] period_tick,
    output logic [NUM_CH-1:0] busy
);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic [1:0] {
        IDLE,
        PHASE,
        RUN
    } state_t;

    localparam cnt_t P_DEF = cnt_t'(2);
    localparam cnt_t T_DEF = cnt_t'(1);
    localparam cnt_t F_DEF = '0;

    logic [NUM_CH-1:0] pend_vec;

    // Out-of-range channel selects never stall, so such writes are accepted and dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if ((cfg_ch == CH_W'(i)) && pend_vec[i]) begin
                cfg_ready = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t state_q, state_d;
        cnt_t   cnt_q, cnt_d;
        cnt_t   p_act_q, p_act_d, t_act_q, t_act_d, f_act_q, f_act_d;
        cnt_t   p_sh_q, p_sh_d, t_sh_q, t_sh_d, f_sh_q, f_sh_d;
        logic   pend_q, pend_d;
        logic   clk_out_q, clk_out_d;
        logic   tick_q, tick_d;
        logic   busy_q, busy_d;
        logic   wr_sel;
        logic   at_end;
        cnt_t   p_eff;

        assign wr_sel = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));
        assign p_eff  = (p_act_q == '0) ? cnt_t'(1) : p_act_q;
        assign at_end = (cnt_q == p_eff - cnt_t'(1));

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            p_act_d   = p_act_q;
            t_act_d   = t_act_q;
            f_act_d   = f_act_q;
            p_sh_d    = p_sh_q;
            t_sh_d    = t_sh_q;
            f_sh_d    = f_sh_q;
            pend_d    = pend_q;
            clk_out_d = (state_q == RUN) && (cnt_q < t_act_q);
            tick_d    = (state_q == RUN) && at_end;

            if (!en[g]) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        p_act_d = p_sh_q;
                        t_act_d = t_sh_q;
                        f_act_d = f_sh_q;
                        pend_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = (f_sh_q != '0) ? PHASE : RUN;
                    end
                    PHASE: begin
                        if (cnt_q == f_act_q - cnt_t'(1)) begin
                            cnt_d   = '0;
                            state_d = RUN;
                        end else begin
                            cnt_d = cnt_q + cnt_t'(1);
                        end
                    end
                    RUN: begin
                        if (at_end) begin
                            cnt_d = '0;
                            if (pend_q) begin
                                p_act_d = p_sh_q;
                                t_act_d = t_sh_q;
                                pend_d  = 1'b0;
                            end
                        end else begin
                            cnt_d = cnt_q + cnt_t'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            // A write in the IDLE-exit cycle lands after the copy above, so it stays pending.
            if (wr_sel) begin
                p_sh_d = cfg_period;
                t_sh_d = cfg_ton;
                f_sh_d = cfg_phase;
                pend_d = 1'b1;
            end

            busy_d = (state_d != IDLE);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                p_act_q   <= P_DEF;
                t_act_q   <= T_DEF;
                f_act_q   <= F_DEF;
                p_sh_q    <= P_DEF;
                t_sh_q    <= T_DEF;
                f_sh_q    <= F_DEF;
                pend_q    <= 1'b0;
                clk_out_q <= 1'b0;
                tick_q    <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                p_act_q   <= p_act_d;
                t_act_q   <= t_act_d;
                f_act_q   <= f_act_d;
                p_sh_q    <= p_sh_d;
                t_sh_q    <= t_sh_d;
                f_sh_q    <= f_sh_d;
                pend_q    <= pend_d;
                clk_out_q <= clk_out_d;
                tick_q    <= tick_d;
                busy_q    <= busy_d;
            end
        end

        assign pend_vec[g]    = pend_q;
        assign clk_out[g]     = clk_out_q;
        assign period_tick[g] = tick_q;
        assign busy[g]        = busy_q;
    end

endmodule

// File: tb/tb_multi_ch_clk_gen.sv
// Scoreboard bench for multi_ch_clk_gen: stimulus queues hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_multi_ch_clk_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 2;

  localparam int SIG_CLK  = 0;
  localparam int SIG_TICK = 1;
  localparam int SIG_BUSY = 2;
  localparam int SIG_RDY  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] en = '0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_period = '0;
  logic [CNT_W-1:0]  cfg_ton = '0;
  logic [CNT_W-1:0]  cfg_phase = '0;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] period_tick;
  logic [NUM_CH-1:0] busy;

  multi_ch_clk_gen #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_ton    (cfg_ton),
    .cfg_phase  (cfg_phase),
    .clk_out    (clk_out),
    .period_tick(period_tick),
    .busy       (busy)
  );

  typedef struct {
    string name;
    int    tgt;
    int    sig;
    int    ch;
    logic  exp;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every negedge, check all expectations due at this cycle.
  always @(negedge clk) begin : mon
    logic act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].tgt <= cyc) begin
        case (sb[i].sig)
          SIG_CLK:  act = clk_out[sb[i].ch];
          SIG_TICK: act = period_tick[sb[i].ch];
          SIG_BUSY: act = busy[sb[i].ch];
          default:  act = cfg_ready;
        endcase
        n_run++;
        if ((sb[i].tgt != cyc) || (act !== sb[i].exp)) begin
          n_fail++;
          $display("FAIL %s ch%0d cyc=%0d got=%b expected=%b",
                   sb[i].name, sb[i].ch, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  // Pattern char j is the expected value after edge E(k0+j), E0 being the next rising edge.
  task automatic push_str(input string nm, input int sig, input int ch, input int k0,
                          input string pat);
    exp_t e;
    for (int j = 0; j < pat.len(); j++) begin
      e.name = $sformatf("%s[k%0d]", nm, k0 + j);
      e.tgt  = cyc + 1 + k0 + j;
      e.sig  = sig;
      e.ch   = ch;
      e.exp  = (pat.getc(j) == 8'd49);
      sb.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr_cfg(input int ch, input int p, input int t, input int f);
    cfg_valid  = 1'b1;
    cfg_ch     = CH_W'(ch);
    cfg_period = CNT_W'(p);
    cfg_ton    = CNT_W'(t);
    cfg_phase  = CNT_W'(f);
    step();
    cfg_valid  = 1'b0;
  endtask

  task automatic do_reset();
    en        = '0;
    cfg_valid = 1'b0;
    rst       = 1'b1;
    steps(2);
    rst       = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    steps(3);

    n_run++;
    if (clk_out !== '0) begin
      n_fail++;
      $display("FAIL init_rst_clk got=%b expected=%b", clk_out, {NUM_CH{1'b0}});
    end
    n_run++;
    if (period_tick !== '0) begin
      n_fail++;
      $display("FAIL init_rst_tick got=%b expected=%b", period_tick, {NUM_CH{1'b0}});
    end
    n_run++;
    if (busy !== '0) begin
      n_fail++;
      $display("FAIL init_rst_busy got=%b expected=%b", busy, {NUM_CH{1'b0}});
    end
    n_run++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL init_rst_rdy got=%b expected=1", cfg_ready);
    end

    rst = 1'b0;

    // Reset state
    for (int c = 0; c < NUM_CH; c++) begin
      push_str("rst_clk", SIG_CLK, c, -1, "0");
      push_str("rst_tick", SIG_TICK, c, -1, "0");
      push_str("rst_busy", SIG_BUSY, c, -1, "0");
    end
    push_str("rst_rdy", SIG_RDY, 0, -1, "1");

    // Defaults on ch0: clk/2
    en = 4'b0001;
    push_str("def_clk", SIG_CLK, 0, 0, "01010");
    push_str("def_tick", SIG_TICK, 0, 0, "00101");
    push_str("def_busy", SIG_BUSY, 0, 0, "1");
    for (int c = 1; c < NUM_CH; c++) begin
      push_str("def_other_clk", SIG_CLK, c, 0, "00000");
      push_str("def_other_busy", SIG_BUSY, c, 0, "0");
    end
    steps(6);

    // Phase delay on ch1: P=4 T=1 F=3
    do_reset();
    wr_cfg(1, 4, 1, 3);
    en = 4'b0010;
    push_str("ph_busy", SIG_BUSY, 1, -1, "01111");
    push_str("ph_rdy", SIG_RDY, 1, -1, "01");
    push_str("ph_clk", SIG_CLK, 1, 0, "0000100010001");
    push_str("ph_tick", SIG_TICK, 1, 0, "000000010001");
    push_str("ph_other_clk", SIG_CLK, 0, 0, "000000");
    steps(14);

    // Mid-period reconfiguration on ch0 with a stalled second write
    do_reset();
    wr_cfg(0, 4, 2, 0);
    en = 4'b0001;
    push_str("upd_clk", SIG_CLK, 0, 0, "011001110001010");
    push_str("upd_tick", SIG_TICK, 0, 0, "000010000010101");
    push_str("upd_rdy", SIG_RDY, 0, 1, "1001000001");
    step();
    step();
    cfg_valid  = 1'b1;
    cfg_ch     = 2'd0;
    cfg_period = 16'd6;
    cfg_ton    = 16'd3;
    cfg_phase  = 16'd0;
    step();
    cfg_period = 16'd2;
    cfg_ton    = 16'd1;
    steps(3);
    cfg_valid  = 1'b0;
    steps(10);

    // Edge values: T=0, T>=P, P=0 with T=1, P=0 with T=0
    do_reset();
    wr_cfg(0, 3, 0, 0);
    wr_cfg(1, 3, 5, 0);
    wr_cfg(2, 0, 1, 0);
    wr_cfg(3, 0, 0, 0);
    en = 4'b1111;
    push_str("t0_clk", SIG_CLK, 0, 0, "0000000000");
    push_str("t0_tick", SIG_TICK, 0, 0, "0001001001");
    push_str("tbig_clk", SIG_CLK, 1, 0, "0111111111");
    push_str("tbig_tick", SIG_TICK, 1, 0, "0001001001");
    push_str("p0_clk", SIG_CLK, 2, 0, "0111111111");
    push_str("p0_tick", SIG_TICK, 2, 0, "0111111111");
    push_str("p0t0_clk", SIG_CLK, 3, 0, "0000000000");
    push_str("p0t0_tick", SIG_TICK, 3, 0, "0111111111");
    steps(11);

    // en[2] dropped mid-period, then re-enabled
    do_reset();
    wr_cfg(2, 4, 2, 2);
    en = 4'b0100;
    push_str("drop_clk", SIG_CLK, 2, 0, "0001100");
    push_str("drop_busy", SIG_BUSY, 2, 0, "1111000");
    steps(4);
    en = 4'b0000;
    steps(3);
    en = 4'b0100;
    push_str("reen_clk", SIG_CLK, 2, 0, "00011001");
    push_str("reen_tick", SIG_TICK, 2, 0, "00000010");
    push_str("reen_busy", SIG_BUSY, 2, 0, "1");
    steps(10);

    // Async reset while all channels run with pending writes
    do_reset();
    for (int c = 0; c < NUM_CH; c++) wr_cfg(c, 5, 2, 1);
    en = 4'b1111;
    steps(2);
    for (int c = 0; c < NUM_CH; c++) wr_cfg(c, 7, 3, 0);
    push_str("pre_rst_rdy", SIG_RDY, 3, -1, "0");
    for (int c = 0; c < NUM_CH; c++) push_str("pre_rst_busy", SIG_BUSY, c, -1, "1");
    step();
    rst = 1'b1;
    #1;
    n_run++;
    if (clk_out !== '0) begin
      n_fail++;
      $display("FAIL async_rst_clk got=%b expected=%b", clk_out, {NUM_CH{1'b0}});
    end
    n_run++;
    if (period_tick !== '0) begin
      n_fail++;
      $display("FAIL async_rst_tick got=%b expected=%b", period_tick, {NUM_CH{1'b0}});
    end
    n_run++;
    if (busy !== '0) begin
      n_fail++;
      $display("FAIL async_rst_busy got=%b expected=%b", busy, {NUM_CH{1'b0}});
    end
    n_run++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_rst_rdy got=%b expected=1", cfg_ready);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      push_str("mid_rst_clk", SIG_CLK, c, -1, "0");
      push_str("mid_rst_tick", SIG_TICK, c, -1, "0");
      push_str("mid_rst_busy", SIG_BUSY, c, -1, "0");
    end
    push_str("mid_rst_rdy", SIG_RDY, 3, -1, "1");
    steps(2);
    rst = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      push_str("post_rst_clk", SIG_CLK, c, 0, "01010");
      push_str("post_rst_tick", SIG_TICK, c, 0, "00101");
    end
    steps(7);

    while (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL %s ch%0d got=unchecked expected=checked", sb[0].name, sb[0].ch);
      void'(sb.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
